// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle logic/arithmetic ops and optional
// iterative MUL (shift-add) / DIVU (restoring) that take WIDTH cycles.
//
// Build option: define SEQ_ALU_MULDIV_EN to build the iterative MUL/DIVU
// datapath. Without it, opcodes 11/12 act as reserved, busy is tied low and
// no counter or iterative datapath is present.
//
// Ports:
//   clk            clock, all state updates on rising edge
//   rst            asynchronous active-high reset
//   start          operation request, sampled when busy=0
//   aluop[3:0]     opcode (0 ADD,1 SUB,2 AND,3 OR,4 SLL,5 SRL,6 SRA,7 SLT,
//                  8 SLTU,9 XOR,10 NOR,11 MUL,12 DIVU,13-15 reserved)
//   in1, in2       operands, sampled with start
//   shamt          shift amount, sampled with start
//   out_lo, out_hi registered result (out_hi: MUL high word / DIVU remainder)
//   zero, ovf      registered flags (out_lo==0; ADD/SUB signed overflow)
//   busy           iterative op in progress
//   done           one-cycle result-valid pulse
module seq_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] out_hi,
    output logic             zero,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpSll  = 4'd4;
    localparam logic [3:0] OpSrl  = 4'd5;
    localparam logic [3:0] OpSra  = 4'd6;
    localparam logic [3:0] OpSlt  = 4'd7;
    localparam logic [3:0] OpSltu = 4'd8;
    localparam logic [3:0] OpXor  = 4'd9;
    localparam logic [3:0] OpNor  = 4'd10;
`ifdef SEQ_ALU_MULDIV_EN
    localparam logic [3:0] OpMul  = 4'd11;
    localparam logic [3:0] OpDivu = 4'd12;
`endif

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic [WIDTH-1:0] sra_res;
    logic             slt;
    logic             sltu;
    logic [WIDTH-1:0] alu_lo;
    logic [WIDTH-1:0] alu_hi;
    logic             alu_ovf;

    assign sum     = in1 + in2;
    assign dif     = in1 - in2;
    assign sra_res = $unsigned($signed(in1) >>> shamt);
    assign slt     = $signed(in1) < $signed(in2);
    assign sltu    = in1 < in2;

    always_comb begin
        alu_lo  = '0;
        alu_hi  = '0;
        alu_ovf = 1'b0;
        case (aluop)
            OpAdd: begin
                alu_lo  = sum;
                alu_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
            end
            OpSub: begin
                alu_lo  = dif;
                alu_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (dif[WIDTH-1] != in1[WIDTH-1]);
            end
            OpAnd:  alu_lo = in1 & in2;
            OpOr:   alu_lo = in1 | in2;
            OpSll:  alu_lo = in1 << shamt;
            OpSrl:  alu_lo = in1 >> shamt;
            OpSra:  alu_lo = sra_res;
            OpSlt:  alu_lo = {{(WIDTH-1){1'b0}}, slt};
            OpSltu: alu_lo = {{(WIDTH-1){1'b0}}, sltu};
            OpXor:  alu_lo = in1 ^ in2;
            OpNor:  alu_lo = ~(in1 | in2);
`ifdef SEQ_ALU_MULDIV_EN
            // Only reached for a zero divisor; nonzero divisors go iterative.
            OpDivu: begin
                alu_lo = '1;
                alu_hi = in1;
            end
`endif
            default: ;  // reserved: zeros
        endcase
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out_lo_q, out_lo_d;
    logic [WIDTH-1:0] out_hi_q, out_hi_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             idle;
    logic             is_iter;

`ifdef SEQ_ALU_MULDIV_EN
    // ------------------------------------------------------------------
    // Iterative MUL / DIVU datapath
    // ------------------------------------------------------------------
    localparam logic [SHW:0] CntInit = WIDTH[SHW:0];
    localparam logic [SHW:0] CntOne  = {{SHW{1'b0}}, 1'b1};

    typedef enum logic [0:0] {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    logic [SHW:0]     cnt_q, cnt_d;
    // acc_hi: MUL partial product high / DIVU remainder
    // acc_lo: MUL multiplier shifting out / DIVU dividend out, quotient in
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             is_div_q, is_div_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    assign idle    = (state_q == IDLE);
    assign busy    = (state_q == RUN);
    assign is_iter = (aluop == OpMul) || ((aluop == OpDivu) && (in2 != '0));

    // Carry bit of the add is shifted into the high word.
    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    // Remainder stays below the divisor, so the MSB of the difference is a
    // reliable borrow flag.
    assign div_diff  = div_shift - {1'b0, opb_q};

    always_comb begin
        if (is_div_q) begin
            if (div_diff[WIDTH]) begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
            end else begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end
`else
    assign idle    = 1'b1;
    assign busy    = 1'b0;
    assign is_iter = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        out_lo_d = out_lo_q;
        out_hi_d = out_hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
`endif

        if (start && idle && !is_iter) begin
            out_lo_d = alu_lo;
            out_hi_d = alu_hi;
            zero_d   = (alu_lo == '0);
            ovf_d    = alu_ovf;
            done_d   = 1'b1;
        end

`ifdef SEQ_ALU_MULDIV_EN
        unique case (state_q)
            IDLE: begin
                if (start && is_iter) begin
                    state_d  = RUN;
                    cnt_d    = CntInit;
                    acc_hi_d = '0;
                    acc_lo_d = in1;
                    opb_d    = in2;
                    is_div_d = (aluop == OpDivu);
                end
            end
            RUN: begin
                cnt_d    = cnt_q - CntOne;
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                if (cnt_q == CntOne) begin
                    state_d  = IDLE;
                    out_lo_d = step_lo;
                    out_hi_d = step_hi;
                    zero_d   = (step_lo == '0);
                    ovf_d    = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`endif
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_lo_q <= '0;
            out_hi_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
`endif
        end else begin
            out_lo_q <= out_lo_d;
            out_hi_q <= out_hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
`ifdef SEQ_ALU_MULDIV_EN
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
`endif
        end
    end

    assign out_lo = out_lo_q;
    assign out_hi = out_hi_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;
    assign done   = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu (WIDTH=32). Expected results come from a vector
// table and a behavioural model; they are queued when an op is started and
// compared when done is seen.
module tb_seq_alu;

`ifdef SEQ_ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam int ITER_CYC = 33;  // negedges from start edge to visible done

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  aluop;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  shamt;
    logic [31:0] out_lo;
    logic [31:0] out_hi;
    logic        zero;
    logic        ovf;
    logic        busy;
    logic        done;

    seq_alu #(
        .WIDTH (32),
        .SHW   (5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .aluop  (aluop),
        .in1    (in1),
        .in2    (in2),
        .shamt  (shamt),
        .out_lo (out_lo),
        .out_hi (out_hi),
        .zero   (zero),
        .ovf    (ovf),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        z;
        logic        v;
        int          cyc;  // negedges after the start edge until done is seen
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t exp_q[$];
    vec_t tbl[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, input logic [31:0] lo,
                                input logic [31:0] hi, input logic z, input logic v,
                                input int cyc);
        vec_t r;
        r.op = op; r.a = a; r.b = b; r.sh = sh;
        r.lo = lo; r.hi = hi; r.z = z; r.v = v; r.cyc = cyc;
        return r;
    endfunction

    function automatic vec_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        vec_t        r;
        logic [31:0] s;
        logic [63:0] p;
        r = mk(op, a, b, sh, 32'd0, 32'd0, 1'b0, 1'b0, 1);
        case (op)
            4'd0: begin s = a + b; r.lo = s; r.v = (a[31] == b[31]) && (s[31] != a[31]); end
            4'd1: begin s = a - b; r.lo = s; r.v = (a[31] != b[31]) && (s[31] != a[31]); end
            4'd2: r.lo = a & b;
            4'd3: r.lo = a | b;
            4'd4: r.lo = a << sh;
            4'd5: r.lo = a >> sh;
            4'd6: r.lo = $unsigned($signed(a) >>> sh);
            4'd7: r.lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8: r.lo = (a < b) ? 32'd1 : 32'd0;
            4'd9: r.lo = a ^ b;
            4'd10: r.lo = ~(a | b);
            4'd11: if (MD) begin
                p = {32'd0, a} * {32'd0, b};
                r.lo = p[31:0]; r.hi = p[63:32]; r.cyc = ITER_CYC;
            end
            4'd12: if (MD) begin
                if (b == 32'd0) begin
                    r.lo = 32'hFFFF_FFFF; r.hi = a;
                end else begin
                    r.lo = a / b; r.hi = a % b; r.cyc = ITER_CYC;
                end
            end
            default: ;
        endcase
        r.z = (r.lo == 32'd0);
        return r;
    endfunction

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                check($sformatf("op%0d_out_lo", e.op), out_lo, e.lo);
                check($sformatf("op%0d_out_hi", e.op), out_hi, e.hi);
                check($sformatf("op%0d_zero", e.op), 32'(zero), 32'(e.z));
                check($sformatf("op%0d_ovf", e.op), 32'(ovf), 32'(e.v));
            end
        end
    end

    // Called at a negedge; returns at the negedge where done is visible.
    task automatic run_vec(input vec_t v);
        int n;
        int busy_bad;
        start = 1'b1;
        aluop = v.op;
        in1   = v.a;
        in2   = v.b;
        shamt = v.sh;
        exp_q.push_back(v);
        @(negedge clk);
        // Scramble inputs so that a design not latching operands is caught.
        start    = 1'b0;
        aluop    = 4'($urandom_range(0, 15));
        in1      = $urandom;
        in2      = $urandom;
        shamt    = 5'($urandom);
        n        = 1;
        busy_bad = 0;
        while (!done && n < v.cyc + 4) begin
            if (busy !== 1'b1) busy_bad++;
            @(negedge clk);
            n++;
        end
        check($sformatf("op%0d_latency", v.op), n, v.cyc);
        check($sformatf("op%0d_busy_run", v.op), busy_bad, 0);
        check($sformatf("op%0d_busy_at_done", v.op), 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(4'd0, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1);
        tbl[1]  = mk(4'd6, 32'h8000_0000, 32'h0, 5'd4, 32'hF800_0000, 32'd0, 1'b0, 1'b0, 1);
        tbl[2]  = mk(4'd7, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'd1, 32'd0, 1'b0, 1'b0, 1);
        tbl[3]  = mk(4'd8, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1);
        tbl[4]  = mk(4'd1, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1, 1);
        tbl[5]  = mk(4'd1, 32'd5, 32'd5, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1);
        tbl[6]  = mk(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 32'd0, 1'b0, 1'b0, 1);
        tbl[7]  = mk(4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0, 32'd0, 1'b0, 1'b0, 1);
        tbl[8]  = mk(4'd9, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FF0_0FF0, 32'd0, 1'b0, 1'b0, 1);
        tbl[9]  = mk(4'd10, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1);
        tbl[10] = mk(4'd4, 32'd1, 32'd5, 5'd31, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 1);
        tbl[11] = mk(4'd5, 32'h8000_0000, 32'd7, 5'd31, 32'd1, 32'd0, 1'b0, 1'b0, 1);
        tbl[12] = mk(4'd13, 32'd1234, 32'd99, 5'd3, 32'd0, 32'd0, 1'b1, 1'b0, 1);
        tbl[13] = mk(4'd11, 32'hFFFF_FFFF, 32'd2, 5'd0, MD ? 32'hFFFF_FFFE : 32'd0,
                     MD ? 32'd1 : 32'd0, !MD, 1'b0, MD ? ITER_CYC : 1);
        tbl[14] = mk(4'd12, 32'd100, 32'd7, 5'd0, MD ? 32'd14 : 32'd0,
                     MD ? 32'd2 : 32'd0, !MD, 1'b0, MD ? ITER_CYC : 1);
        tbl[15] = mk(4'd12, 32'd5, 32'd0, 5'd0, MD ? 32'hFFFF_FFFF : 32'd0,
                     MD ? 32'd5 : 32'd0, !MD, 1'b0, 1);
        tbl[16] = mk(4'd11, 32'd3, 32'd4, 5'd0, MD ? 32'd12 : 32'd0, 32'd0, !MD, 1'b0,
                     MD ? ITER_CYC : 1);
        tbl[17] = mk(4'd0, 32'd2, 32'd3, 5'd0, 32'd5, 32'd0, 1'b0, 1'b0, 1);
        tbl[18] = mk(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1);

        start = 1'b0;
        aluop = 4'd0;
        in1   = 32'd0;
        in2   = 32'd0;
        shamt = 5'd0;
        rst   = 1'b0;
        #1 rst = 1'b1;
        #1;
        // Reset takes effect without any clock edge.
        check("rst_out_lo", out_lo, 32'd0);
        check("rst_out_hi", out_hi, 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table vectors, issued back-to-back in the done cycle.
        for (int i = 0; i < 19; i++) run_vec(tbl[i]);

        // Random vectors against the model.
        for (int i = 0; i < 24; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if (i % 3 == 0) b = b >> $urandom_range(8, 31);
            run_vec(model(op, a, b, 5'($urandom)));
        end

        // Known result that must hold while an op runs / until reset.
        run_vec(model(4'd0, 32'd1, 32'd1, 5'd0));
`ifdef SEQ_ALU_MULDIV_EN
        // MUL that gets a start pulse mid-run and is then aborted by reset.
        start = 1'b1;
        aluop = 4'd11;
        in1   = 32'd7;
        in2   = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1;
        aluop = 4'd1;
        in1   = 32'd50;
        in2   = 32'd8;
        @(negedge clk);
        start = 1'b0;
        check("ignored_start_busy", 32'(busy), 32'd1);
        check("hold_out_lo_during_run", out_lo, 32'd2);
        check("hold_zero_during_run", 32'(zero), 32'd0);
        repeat (9) @(negedge clk);
        check("busy_before_abort", 32'(busy), 32'd1);
`endif
        #2 rst = 1'b1;
        #1;
        check("abort_out_lo", out_lo, 32'd0);
        check("abort_out_hi", out_hi, 32'd0);
        check("abort_zero", 32'(zero), 32'd1);
        check("abort_ovf", 32'(ovf), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(tbl[17]);
        @(negedge clk);
        check("done_pulse_width", 32'(done), 32'd0);
        check("hold_after_done", out_lo, 32'd5);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (power of two, 8..64).
REQ-002 SHALL have parameter SHW, default 5, shift-amount width equal to log2(WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  operation request, sampled on clk when busy=0.
REQ-006 SHALL have port aluop  input  4  operation code per REQ-012.
REQ-007 SHALL have ports in1, in2  input  WIDTH  operands, sampled with start.
REQ-008 SHALL have port shamt  input  SHW  shift amount, sampled with start.
REQ-009 SHALL have ports out_lo, out_hi  output  WIDTH  registered result (out_hi: MUL high word / DIVU remainder, else 0).
REQ-010 SHALL have ports zero, ovf  output  1  registered flags: out_lo==0; signed overflow of ADD/SUB (0 for all other ops).
REQ-011 SHALL have ports busy, done  output  1  iterative op in progress; one-cycle result-valid pulse.

Function
REQ-012 aluop SHALL decode as: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL, 6 SRA, 7 SLT (signed), 8 SLTU, 9 XOR, 10 NOR, 11 MUL (unsigned, 2*WIDTH product), 12 DIVU (unsigned), 13-15 reserved.
REQ-013 The FSM SHALL have states IDLE and RUN; busy SHALL equal (state==RUN).
REQ-014 In IDLE with start=1 and a single-cycle op (0-10, 13-15), results and flags SHALL register at that edge, done SHALL pulse for the following cycle, state stays IDLE.
REQ-015 Reserved opcodes SHALL produce out_lo=0, out_hi=0, ovf=0, zero=1, done pulse.
REQ-016 In IDLE with start=1 and op 11/12, operands SHALL latch, a counter SHALL load WIDTH, and state SHALL go to RUN.
REQ-017 In RUN, one shift-add (MUL) or restoring-subtract (DIVU) iteration SHALL occur per edge; after the WIDTH-th iteration the result SHALL register, done SHALL pulse, and state SHALL return to IDLE.
REQ-018 For start sampled at edge E0 with an iterative op, busy SHALL be 1 after E0 through E0+WIDTH-1 and done SHALL be 1 only in the cycle after E0+WIDTH.
REQ-019 start while busy=1 SHALL be ignored; operands and outputs of the running op SHALL be unaffected.
REQ-020 DIVU with in2=0 SHALL complete as a single-cycle op: out_lo all ones, out_hi=in1.
REQ-021 Shifts SHALL use shamt only; SRA SHALL replicate in1[WIDTH-1].
REQ-022 ADD/SUB SHALL wrap modulo 2^WIDTH; ovf SHALL set when operand signs imply signed overflow.
REQ-023 out_lo, out_hi, zero, ovf SHALL hold their last value until the next result registers; they SHALL NOT change during RUN.
REQ-024 start in the cycle done is high SHALL be accepted (back-to-back ops, no bubble).

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE, counter=0, out_lo=0, out_hi=0, ovf=0, zero=1, busy=0, done=0, regardless of clk.
REQ-026 rst asserted during RUN SHALL abort the op with no done pulse; the first edge after release SHALL honour start.

Configuration
REQ-027 Macro SEQ_ALU_MULDIV_EN defined: MUL/DIVU SHALL be implemented per REQ-016..REQ-020.
REQ-028 Macro SEQ_ALU_MULDIV_EN undefined: ops 11/12 SHALL behave as reserved (REQ-015), busy SHALL be constant 0, and no iterative datapath or counter SHALL be synthesised.

Verification (WIDTH=32)
REQ-029 ADD 0x7FFFFFFF+0x00000001 -> out_lo=0x80000000, ovf=1, zero=0, done one cycle after start, busy=0 throughout.
REQ-030 SRA in1=0x80000000, shamt=4 -> out_lo=0xF8000000; SLT 0xFFFFFFFF,0x00000001 -> 1; SLTU same operands -> 0.
REQ-031 MUL 0xFFFFFFFF x 0x00000002 -> out_hi=0x00000001, out_lo=0xFFFFFFFE, done exactly 32 edges after E0, busy=1 for 32 cycles.
REQ-032 DIVU 100/7 -> out_lo=14, out_hi=2; DIVU 5/0 -> out_lo=0xFFFFFFFF, out_hi=5, done after 1 cycle.
REQ-033 MUL started, SUB start pulsed at iteration 10, rst pulsed at iteration 20 -> SUB ignored, no done, outputs at reset values, next ADD 2+3 -> 5 one cycle after start.
REQ-034 Macro undefined: MUL 3x4 -> out_lo=0, out_hi=0, zero=1, done after 1 cycle, busy never 1.
